// File: rtl/glb_bank_responder.sv
`default_nettype none
// ============================================================================
//  Module      : glb_bank_responder
//  Description : Bank-side responder for GLB SRAM packets. Registers incoming
//                write / read-request packets, issues one single-port SRAM
//                access per cycle (reads first), parks colliding writes in a
//                small circular write buffer that drains on read-free cycles,
//                and forwards buffered bytes into read responses.
//  Ports       : clk, reset          clock, synchronous active-high reset
//                wr_packet           {wr_en, wr_strb[NB], wr_addr, wr_data}
//                rdrq_packet         {rd_en, rd_addr}
//                rdrs_packet         {rd_data, rd_data_valid}
//                sram_cen/wen/addr   SRAM access enable, write select, word addr
//                sram_data_in        SRAM write data
//                sram_bit_wen        SRAM per-bit write mask (byte strobe x8)
//                sram_data_out       SRAM read data, SRAM_LATENCY after issue
//                wr_overflow         sticky: a write was dropped (FIFO full)
//                err_clr             clears wr_overflow
//  Revision    : 1.0  initial release
// ============================================================================
module glb_bank_responder #(
    parameter int BANK_DATA_WIDTH = 64,
    parameter int GLB_ADDR_WIDTH  = 22,
    parameter int BANK_ADDR_WIDTH = 17,
    parameter int SRAM_LATENCY    = 1,
    parameter int WB_DEPTH        = 4
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic [BANK_DATA_WIDTH+BANK_DATA_WIDTH/8+GLB_ADDR_WIDTH:0] wr_packet,
    input  logic [GLB_ADDR_WIDTH:0]                                   rdrq_packet,
    output logic [BANK_DATA_WIDTH:0]                                  rdrs_packet,
    output logic                                                      sram_cen,
    output logic                                                      sram_wen,
    output logic [BANK_ADDR_WIDTH-$clog2(BANK_DATA_WIDTH/8)-1:0]      sram_addr,
    output logic [BANK_DATA_WIDTH-1:0]                                sram_data_in,
    output logic [BANK_DATA_WIDTH-1:0]                                sram_bit_wen,
    input  logic [BANK_DATA_WIDTH-1:0]                                sram_data_out,
    output logic                                                      wr_overflow,
    input  logic                                                      err_clr
);

    localparam int c_NB    = BANK_DATA_WIDTH / 8;
    localparam int c_OFF   = $clog2(c_NB);
    localparam int c_WAW   = BANK_ADDR_WIDTH - c_OFF;
    localparam int c_PW    = $clog2(WB_DEPTH);
    localparam int c_CW    = c_PW + 1;
    localparam int c_WR_EN = BANK_DATA_WIDTH + c_NB + GLB_ADDR_WIDTH;

    function automatic logic [BANK_DATA_WIDTH-1:0] f_expand(input logic [c_NB-1:0] strb);
        logic [BANK_DATA_WIDTH-1:0] v;
        for (int b = 0; b < c_NB; b++) begin
            v[8*b +: 8] = {8{strb[b]}};
        end
        return v;
    endfunction

    // Bank decode is upstream and the SRAM is word addressed, so the GLB bits
    // above the bank and the byte offset within a word are never looked at.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{rdrq_packet[GLB_ADDR_WIDTH-1:BANK_ADDR_WIDTH],
                                  rdrq_packet[c_OFF-1:0],
                                  wr_packet[BANK_DATA_WIDTH+GLB_ADDR_WIDTH-1:BANK_DATA_WIDTH+BANK_ADDR_WIDTH],
                                  wr_packet[BANK_DATA_WIDTH+c_OFF-1:BANK_DATA_WIDTH]};

    // ---------------------------------------------------------------- stage 0
    logic                       r_rd_en;
    logic [c_WAW-1:0]           r_rd_waddr;
    logic                       r_wr_en;
    logic [c_NB-1:0]            r_wr_strb;
    logic [c_WAW-1:0]           r_wr_waddr;
    logic [BANK_DATA_WIDTH-1:0] r_wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en    <= 1'b0;
            r_rd_waddr <= '0;
            r_wr_en    <= 1'b0;
            r_wr_strb  <= '0;
            r_wr_waddr <= '0;
            r_wr_data  <= '0;
        end else begin
            r_rd_en    <= rdrq_packet[GLB_ADDR_WIDTH];
            r_rd_waddr <= rdrq_packet[BANK_ADDR_WIDTH-1:c_OFF];
            r_wr_en    <= wr_packet[c_WR_EN];
            r_wr_strb  <= wr_packet[BANK_DATA_WIDTH+GLB_ADDR_WIDTH +: c_NB];
            r_wr_waddr <= wr_packet[BANK_DATA_WIDTH+BANK_ADDR_WIDTH-1:BANK_DATA_WIDTH+c_OFF];
            r_wr_data  <= wr_packet[BANK_DATA_WIDTH-1:0];
        end
    end

    // ---------------------------------------------------------- write buffer
    logic [c_WAW-1:0]           r_fifo_waddr [WB_DEPTH];
    logic [c_NB-1:0]            r_fifo_strb  [WB_DEPTH];
    logic [BANK_DATA_WIDTH-1:0] r_fifo_data  [WB_DEPTH];
    logic [c_PW-1:0]            r_rd_ptr;
    logic [c_PW-1:0]            r_wr_ptr;
    logic [c_CW-1:0]            r_cnt;

    logic w_full;
    assign w_full = (r_cnt == c_CW'(WB_DEPTH));

    // ---------------------------------------------------------- issue stage
    logic                       w_push;
    logic                       w_pop;
    logic                       w_drop;
    logic                       w_sram_go;
    logic                       w_sram_we;
    logic [c_WAW-1:0]           w_sram_addr;
    logic [BANK_DATA_WIDTH-1:0] w_sram_data;
    logic [BANK_DATA_WIDTH-1:0] w_sram_mask;

    logic                       r_sram_cen;
    logic                       r_sram_wen;
    logic [c_WAW-1:0]           r_sram_addr;
    logic [BANK_DATA_WIDTH-1:0] r_sram_data_in;
    logic [BANK_DATA_WIDTH-1:0] r_sram_bit_wen;

    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_drop      = 1'b0;
        w_sram_go   = 1'b0;
        w_sram_we   = 1'b0;
        // Hold the data-side SRAM pins when they carry nothing new.
        w_sram_addr = r_sram_addr;
        w_sram_data = r_sram_data_in;
        w_sram_mask = r_sram_bit_wen;
        if (r_rd_en) begin
            w_sram_go   = 1'b1;
            w_sram_addr = r_rd_waddr;
            if (r_wr_en) begin
                w_drop = w_full;
                w_push = !w_full;
            end
        end else if (r_cnt != '0) begin
            // Drain the oldest parked write; a same-cycle write takes the
            // freed slot, which is why push on a full buffer is legal here.
            w_sram_go   = 1'b1;
            w_sram_we   = 1'b1;
            w_sram_addr = r_fifo_waddr[r_rd_ptr];
            w_sram_data = r_fifo_data[r_rd_ptr];
            w_sram_mask = f_expand(r_fifo_strb[r_rd_ptr]);
            w_pop       = 1'b1;
            w_push      = r_wr_en;
        end else if (r_wr_en) begin
            w_sram_go   = 1'b1;
            w_sram_we   = 1'b1;
            w_sram_addr = r_wr_waddr;
            w_sram_data = r_wr_data;
            w_sram_mask = f_expand(r_wr_strb);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_cnt <= r_cnt + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_waddr[r_wr_ptr] <= r_wr_waddr;
            r_fifo_strb[r_wr_ptr]  <= r_wr_strb;
            r_fifo_data[r_wr_ptr]  <= r_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sram_cen     <= 1'b0;
            r_sram_wen     <= 1'b0;
            r_sram_addr    <= '0;
            r_sram_data_in <= '0;
            r_sram_bit_wen <= '0;
        end else begin
            r_sram_cen     <= w_sram_go;
            r_sram_wen     <= w_sram_we;
            r_sram_addr    <= w_sram_addr;
            r_sram_data_in <= w_sram_data;
            r_sram_bit_wen <= w_sram_mask;
        end
    end

    // ------------------------------------------------------------ forwarding
    // Walk the buffer oldest to youngest so the youngest matching byte wins.
    logic [BANK_DATA_WIDTH-1:0] w_fwd_data;
    logic [c_NB-1:0]            w_fwd_mask;

    always_comb begin
        logic [c_PW-1:0] v_idx;
        v_idx      = '0;
        w_fwd_data = '0;
        w_fwd_mask = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            v_idx = r_rd_ptr + c_PW'(i);
            if ((c_CW'(i) < r_cnt) && (r_fifo_waddr[v_idx] == r_rd_waddr)) begin
                for (int b = 0; b < c_NB; b++) begin
                    if (r_fifo_strb[v_idx][b]) begin
                        w_fwd_mask[b]        = 1'b1;
                        w_fwd_data[8*b +: 8] = r_fifo_data[v_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    // --------------------------------------------------------- read pipeline
    // Entry 0 is loaded together with the SRAM read issue; entry SRAM_LATENCY
    // lines up with the cycle in which sram_data_out carries that read.
    logic [SRAM_LATENCY:0]      r_pipe_vld;
    logic [BANK_DATA_WIDTH-1:0] r_pipe_data [SRAM_LATENCY+1];
    logic [c_NB-1:0]            r_pipe_mask [SRAM_LATENCY+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld <= {r_pipe_vld[SRAM_LATENCY-1:0], r_rd_en};
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_data[0] <= w_fwd_data;
        r_pipe_mask[0] <= w_fwd_mask;
        for (int s = 1; s <= SRAM_LATENCY; s++) begin
            r_pipe_data[s] <= r_pipe_data[s-1];
            r_pipe_mask[s] <= r_pipe_mask[s-1];
        end
    end

    logic [BANK_DATA_WIDTH-1:0] w_merged;

    always_comb begin
        w_merged = sram_data_out;
        for (int b = 0; b < c_NB; b++) begin
            if (r_pipe_mask[SRAM_LATENCY][b]) begin
                w_merged[8*b +: 8] = r_pipe_data[SRAM_LATENCY][8*b +: 8];
            end
        end
    end

    logic                       r_rd_valid;
    logic [BANK_DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= r_pipe_vld[SRAM_LATENCY];
            if (r_pipe_vld[SRAM_LATENCY]) begin
                r_rd_data <= w_merged;
            end
        end
    end

    // --------------------------------------------------------- overflow flag
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (err_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign rdrs_packet  = {r_rd_data, r_rd_valid};
    assign sram_cen     = r_sram_cen;
    assign sram_wen     = r_sram_wen;
    assign sram_addr    = r_sram_addr;
    assign sram_data_in = r_sram_data_in;
    assign sram_bit_wen = r_sram_bit_wen;
    assign wr_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_glb_bank_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glb_bank_responder
//  Description : Self-checking bench for glb_bank_responder. Behavioural SRAM,
//                a write-ordered memory image with a queue of parked writes as
//                reference, directed scenarios plus a random read/write mix.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_glb_bank_responder;

    localparam int DW    = 64;
    localparam int GW    = 22;
    localparam int BW    = 17;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int WAW   = 14;
    localparam int NW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [94:0]   wr_packet;
    logic [22:0]   rdrq_packet;
    logic [64:0]   rdrs_packet;
    logic          sram_cen;
    logic          sram_wen;
    logic [WAW-1:0] sram_addr;
    logic [DW-1:0] sram_data_in;
    logic [DW-1:0] sram_bit_wen;
    logic [DW-1:0] sram_data_out;
    logic          wr_overflow;
    logic          err_clr;

    always #5 clk = ~clk;

    glb_bank_responder #(
        .BANK_DATA_WIDTH(DW),
        .GLB_ADDR_WIDTH (GW),
        .BANK_ADDR_WIDTH(BW),
        .SRAM_LATENCY   (LAT),
        .WB_DEPTH       (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_packet    (wr_packet),
        .rdrq_packet  (rdrq_packet),
        .rdrs_packet  (rdrs_packet),
        .sram_cen     (sram_cen),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_data_in (sram_data_in),
        .sram_bit_wen (sram_bit_wen),
        .sram_data_out(sram_data_out),
        .wr_overflow  (wr_overflow),
        .err_clr      (err_clr)
    );

    // ------------------------------------------------------ behavioural SRAM
    logic [DW-1:0]  mem [0:(1<<WAW)-1];
    logic [DW-1:0]  rpipe [0:LAT-1];
    logic           pl_en = 1'b0;
    logic [WAW-1:0] pl_addr = '0;
    logic [DW-1:0]  pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (sram_cen && sram_wen)
            mem[sram_addr] <= (mem[sram_addr] & ~sram_bit_wen) | (sram_data_in & sram_bit_wen);
        if (sram_cen && !sram_wen) rpipe[0] <= mem[sram_addr];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign sram_data_out = rpipe[LAT-1];

    // ------------------------------------------------------- reference model
    typedef struct packed {
        logic [WAW-1:0] wa;
        logic [7:0]     strb;
        logic [DW-1:0]  data;
    } wr_t;
    typedef struct packed {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic [DW-1:0] ref_mem [0:NW-1];
    wr_t           pend[$];
    rd_t           expq[$];
    bit            ovf = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_vld = 0;
    int n_killed = 0;
    bit started = 1'b0;
    bit have_last = 1'b0;
    logic [DW-1:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] view(input int w);
        logic [DW-1:0] v;
        v = ref_mem[w];
        foreach (pend[i])
            if (pend[i].wa == WAW'(w))
                for (int b = 0; b < 8; b++)
                    if (pend[i].strb[b]) v[8*b +: 8] = pend[i].data[8*b +: 8];
        return v;
    endfunction

    function automatic void commit(input wr_t e);
        for (int b = 0; b < 8; b++)
            if (e.strb[b]) ref_mem[e.wa][8*b +: 8] = e.data[8*b +: 8];
    endfunction

    // Byte address for a word: random bank-select bits and byte offset.
    function automatic logic [GW-1:0] mk(input int w);
        logic [4:0] hi;
        logic [2:0] lo;
        hi = 5'($urandom);
        lo = 3'($urandom);
        return {hi, WAW'(w), lo};
    endfunction

    task automatic drive(input bit rd, input int rw, input bit wr, input int ww,
                         input logic [7:0] strb, input logic [DW-1:0] wd, input bit clr);
        wr_t e;
        rdrq_packet = {rd, mk(rw)};
        wr_packet   = {wr, strb, mk(ww), wd};
        err_clr     = clr;
        e = '{wa: WAW'(ww), strb: strb, data: wd};
        if (clr) ovf = 1'b0;
        if (rd) begin
            expq.push_back('{data: view(rw), due: cyc + 1 + LAT + 2});
            n_rd++;
            if (wr) begin
                if (pend.size() == DEPTH) ovf = 1'b1;
                else pend.push_back(e);
            end
        end else if (pend.size() > 0) begin
            commit(pend.pop_front());
            if (wr) pend.push_back(e);
        end else if (wr) begin
            commit(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 8'h00, '0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        rdrq_packet = '0;
        wr_packet   = '0;
        err_clr     = 1'b0;
        n_killed   += expq.size();
        expq.delete();
        pend.delete();
        ovf       = 1'b0;
        have_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------------- response monitor
    always @(negedge clk) begin
        if (started && !reset) begin
            if (rdrs_packet[0]) begin
                n_vld++;
                if (expq.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    rd_t e;
                    e = expq.pop_front();
                    check("rd_data", rdrs_packet[64:1], e.data);
                    check("rd_latency", 64'(cyc), 64'(e.due));
                end
                last_rd   = rdrs_packet[64:1];
                have_last = 1'b1;
            end else begin
                if (have_last) check("rd_hold", rdrs_packet[64:1], last_rd);
                if (expq.size() > 0 && cyc > expq[0].due) begin
                    check("rd_timeout", 64'd0, 64'd1);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        logic [DW-1:0] old20, old21;
        reset       = 1'b1;
        rdrq_packet = '0;
        wr_packet   = '0;
        err_clr     = 1'b0;
        for (int w = 0; w < NW; w++) begin
            logic [DW-1:0] d;
            d = {$urandom, $urandom};
            if (w == 2) d = 64'hA5A5_A5A5_A5A5_A5A5;
            if (w == 8) d = 64'h0102_0304_0506_0708;
            pl_en = 1'b1; pl_addr = WAW'(w); pl_data = d;
            ref_mem[w] = d;
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rdrs", 64'(rdrs_packet), 64'd0);
        check("rst_cen", 64'(sram_cen), 64'd0);
        check("rst_wen", 64'(sram_wen), 64'd0);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_din", sram_data_in, 64'd0);
        check("rst_bwen", sram_bit_wen, 64'd0);
        check("rst_ovf", 64'(wr_overflow), 64'd0);
        reset   = 1'b0;
        started = 1'b1;

        // Read miss with exact latency.
        drive(1'b1, 2, 1'b0, 0, 8'h00, '0, 1'b0);
        idle(5);
        check("t1_data", last_rd, 64'hA5A5_A5A5_A5A5_A5A5);

        // Collision: read wins, write drains on the next idle cycle.
        drive(1'b1, 5, 1'b1, 4, 8'hFF, 64'h1111, 1'b0);
        idle(2);
        drive(1'b1, 4, 1'b0, 0, 8'h00, '0, 1'b0);
        idle(5);
        check("t2_data", last_rd, 64'h0000_0000_0000_1111);

        // Byte-wise forward merge from two parked writes.
        drive(1'b1, 31, 1'b1, 8, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        drive(1'b1, 31, 1'b1, 8, 8'h03, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
        drive(1'b1, 8, 1'b0, 0, 8'h00, '0, 1'b0);
        idle(6);
        check("t3_data", last_rd, 64'h0102_0304_AAAA_BBBB);
        check("t3_sram", mem[8], 64'h0102_0304_AAAA_BBBB);

        // Overflow: fifth parked write is dropped, first four land in order.
        drive(1'b1, 31, 1'b1, 16, 8'hFF, 64'h1111_1111_1111_1111, 1'b0);
        drive(1'b1, 31, 1'b1, 16, 8'h0F, 64'h2222_2222_2222_2222, 1'b0);
        drive(1'b1, 31, 1'b1, 16, 8'h03, 64'h3333_3333_3333_3333, 1'b0);
        drive(1'b1, 31, 1'b1, 16, 8'h01, 64'h4444_4444_4444_4444, 1'b0);
        drive(1'b1, 31, 1'b1, 16, 8'hFF, 64'h5555_5555_5555_5555, 1'b0);
        drive(1'b1, 30, 1'b0, 0, 8'h00, '0, 1'b0);
        drive(1'b1, 30, 1'b0, 0, 8'h00, '0, 1'b0);
        check("t4_ovf_set", 64'(wr_overflow), 64'd1);
        idle(8);
        check("t4_ovf_sticky", 64'(wr_overflow), 64'(ovf));
        check("t4_sram", mem[16], 64'h1111_1111_2222_3344);
        drive(1'b0, 0, 1'b0, 0, 8'h00, '0, 1'b1);
        idle(2);
        check("t4_ovf_clr", 64'(wr_overflow), 64'd0);

        // Reset mid-flight with two writes parked.
        old20 = ref_mem[20];
        old21 = ref_mem[21];
        drive(1'b1, 24, 1'b1, 20, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1'b0);
        drive(1'b1, 25, 1'b1, 21, 8'hFF, 64'hDEAD_BEEF_0000_0002, 1'b0);
        drive(1'b1, 26, 1'b0, 0, 8'h00, '0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("t5_cen", 64'(sram_cen), 64'd0);
        end
        check("t5_ovf", 64'(wr_overflow), 64'd0);
        drive(1'b1, 20, 1'b0, 0, 8'h00, '0, 1'b0);
        idle(5);
        check("t5_old20", last_rd, old20);
        drive(1'b1, 21, 1'b0, 0, 8'h00, '0, 1'b0);
        idle(5);
        check("t5_old21", last_rd, old21);

        // Random mix against the reference image.
        for (int i = 0; i < 400; i++) begin
            bit rd, wr;
            logic [7:0] st;
            rd = ($urandom_range(0, 99) < 60);
            wr = ($urandom_range(0, 99) < 50);
            st = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            drive(rd, $urandom_range(0, 15), wr, $urandom_range(0, 15), st,
                  {$urandom, $urandom}, 1'b0);
        end
        idle(12);
        check("rnd_ovf", 64'(wr_overflow), 64'(ovf));
        check("rd_pending", 64'(expq.size()), 64'd0);
        check("rd_count", 64'(n_vld), 64'(n_rd - n_killed));
        for (int w = 0; w < NW; w++) check("sram_image", mem[w], ref_mem[w]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
